// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared codes for the self-sequenced datapath: ALU op, shift,
//                writeback source, status bit positions and FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SHIFT_NONE = 2'b00,
        SHIFT_LSL1 = 2'b01,
        SHIFT_LSR1 = 2'b10,
        SHIFT_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        VSEL_C     = 2'b00,
        VSEL_PC    = 2'b01,
        VSEL_IMM   = 2'b10,
        VSEL_MDATA = 2'b11
    } vsel_e;

    localparam int STAT_Z = 0;
    localparam int STAT_C = 1;
    localparam int STAT_N = 2;
    localparam int STAT_V = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_if
//  Description : Command handshake, memory/PC inputs, results and debug port
//                of the datapath, bundled for the decoder-side connection.
//  Revision    : 1.0  initial release
// ============================================================================
interface datapath_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 9
);
    localparam int RW = $clog2(NREGS);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_aluop;
    logic [1:0]       cmd_shift;
    logic             cmd_asel;
    logic             cmd_bsel;
    logic [1:0]       cmd_vsel;
    logic [RW-1:0]    cmd_rn;
    logic [RW-1:0]    cmd_rm;
    logic [RW-1:0]    cmd_rd;
    logic             cmd_wb;
    logic             cmd_loads;
    logic [WIDTH-1:0] cmd_imm;
    logic [WIDTH-1:0] mdata;
    logic [PCW-1:0]   pc;
    logic [WIDTH-1:0] c_out;
    logic [3:0]       status;
    logic             done;
    logic [RW-1:0]    dbg_num;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output cmd_valid, cmd_aluop, cmd_shift, cmd_asel, cmd_bsel, cmd_vsel,
               cmd_rn, cmd_rm, cmd_rd, cmd_wb, cmd_loads, cmd_imm,
               mdata, pc, dbg_num,
        input  cmd_ready, c_out, status, done, dbg_data
    );

    modport slave (
        input  cmd_valid, cmd_aluop, cmd_shift, cmd_asel, cmd_bsel, cmd_vsel,
               cmd_rn, cmd_rm, cmd_rd, cmd_wb, cmd_loads, cmd_imm,
               mdata, pc, dbg_num,
        output cmd_ready, c_out, status, done, dbg_data
    );

endinterface
`default_nettype wire

// File: rtl/regfile_p.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_p
//  Description : Register file with one synchronous write port and two
//                combinational read ports (datapath and debug).
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_p #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_we,
    input  wire logic [$clog2(NREGS)-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic [$clog2(NREGS)-1:0] i_raddr,
    output logic      [WIDTH-1:0]         o_rdata,
    input  wire logic [$clog2(NREGS)-1:0] i_dbg_addr,
    output logic      [WIDTH-1:0]         o_dbg_data
);

    logic [WIDTH-1:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata    = r_regs[i_raddr];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_seq
//  Description : Self-sequenced datapath: register file, A/B/C registers,
//                B shifter, ALU and status, one command per handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PCW   = 9
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    datapath_if.slave   bus
);

    localparam int RW  = $clog2(NREGS);
    localparam int MSB = WIDTH - 1;

    state_e           r_state;
    alu_op_e          r_aluop;
    shift_e           r_shift;
    vsel_e            r_vsel;
    logic             r_asel;
    logic             r_bsel;
    logic             r_wb;
    logic             r_loads;
    logic [RW-1:0]    r_rn;
    logic [RW-1:0]    r_rm;
    logic [RW-1:0]    r_rd;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [3:0]       r_status;
    logic             r_done;

    logic [RW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_we;
    logic [WIDTH-1:0] w_wdata;
    logic [PCW-1:0]   w_pc;
    logic [WIDTH-1:0] w_a_op;
    logic [WIDTH-1:0] w_b_sh;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    // The single datapath read port serves rn in RDA and rm in RDB.
    assign w_rd_addr = (r_state == RDA) ? r_rn : r_rm;
    assign w_we      = (r_state == WB) && r_wb;
    assign w_pc      = bus.pc;

    regfile_p #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_rd),
        .i_wdata    (w_wdata),
        .i_raddr    (w_rd_addr),
        .o_rdata    (w_rd_data),
        .i_dbg_addr (bus.dbg_num),
        .o_dbg_data (bus.dbg_data)
    );

    always_comb begin
        w_b_sh = r_b;
        case (r_shift)
            SHIFT_LSL1: w_b_sh = {r_b[MSB-1:0], 1'b0};
            SHIFT_LSR1: w_b_sh = {1'b0, r_b[MSB:1]};
            SHIFT_ASR1: w_b_sh = {r_b[MSB], r_b[MSB:1]};
            default:    w_b_sh = r_b;
        endcase
    end

    assign w_a_op = r_asel ? '0 : r_a;
    assign w_b_op = r_bsel ? r_imm : w_b_sh;

    // Subtraction as A + ~B + 1 so the carry-out is the inverted borrow.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_aluop)
            ALU_ADD: begin
                w_sum   = {1'b0, w_a_op} + {1'b0, w_b_op};
                w_res   = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (w_a_op[MSB] == w_b_op[MSB]) && (w_res[MSB] != w_a_op[MSB]);
            end
            ALU_SUB: begin
                w_sum   = {1'b0, w_a_op} + {1'b0, ~w_b_op} + (WIDTH+1)'(1);
                w_res   = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (w_a_op[MSB] != w_b_op[MSB]) && (w_res[MSB] != w_a_op[MSB]);
            end
            ALU_AND: w_res = w_a_op & w_b_op;
            default: w_res = ~w_b_op;
        endcase
    end

    always_comb begin
        w_wdata = r_c;
        case (r_vsel)
            VSEL_C:     w_wdata = r_c;
            VSEL_PC:    w_wdata = WIDTH'(w_pc);
            VSEL_IMM:   w_wdata = r_imm;
            default:    w_wdata = bus.mdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_aluop  <= ALU_ADD;
            r_shift  <= SHIFT_NONE;
            r_vsel   <= VSEL_C;
            r_asel   <= 1'b0;
            r_bsel   <= 1'b0;
            r_wb     <= 1'b0;
            r_loads  <= 1'b0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_aluop <= alu_op_e'(bus.cmd_aluop);
                        r_shift <= shift_e'(bus.cmd_shift);
                        r_vsel  <= vsel_e'(bus.cmd_vsel);
                        r_asel  <= bus.cmd_asel;
                        r_bsel  <= bus.cmd_bsel;
                        r_wb    <= bus.cmd_wb;
                        r_loads <= bus.cmd_loads;
                        r_rn    <= bus.cmd_rn;
                        r_rm    <= bus.cmd_rm;
                        r_rd    <= bus.cmd_rd;
                        r_imm   <= bus.cmd_imm;
                        // Non-ALU writebacks bypass the operand fetch entirely.
                        r_state <= (vsel_e'(bus.cmd_vsel) == VSEL_C) ? RDA : WB;
                    end
                end
                RDA: begin
                    r_a     <= w_rd_data;
                    r_state <= RDB;
                end
                RDB: begin
                    r_b     <= w_rd_data;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_c <= w_res;
                    if (r_loads) begin
                        r_status[STAT_Z] <= (w_res == '0);
                        r_status[STAT_C] <= w_carry;
                        r_status[STAT_N] <= w_res[MSB];
                        r_status[STAT_V] <= w_ovf;
                    end
                    r_state <= WB;
                end
                WB: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = rst_n && (r_state == IDLE);
    assign bus.c_out     = r_c;
    assign bus.status    = r_status;
    assign bus.done      = r_done;

endmodule
`default_nettype wire
